// File: rtl/zint_arb.sv
// Z80 maskable-interrupt arbiter: NSRC start pulses -> pending flags -> /INT, IM2 vector on ack.
// Latency: start to int_n low 1 clk; intack rise to im2vect valid and winner cleared 1 clk.
// Backpressure: none; a restart while pending sets a sticky overrun flag instead of queueing.
//
// Ports: clk/res_n (async active-low), int_start/intmask/ovr_clr per source,
//        vdos, intack (M1 & IORQ level); outputs im2vect, int_n, pending, ovr.
module zint_arb #(
    parameter int         NSRC      = 4,
    parameter logic [7:0] VECT_BASE = 8'hFF,
    parameter logic [7:0] VECT_DUM  = 8'hFF,
    parameter logic [7:0] LOSE_MASK = 8'b0000_0011,
    parameter logic [7:0] TMO_MASK  = 8'b0000_0001,
    parameter int         TMO       = 32
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic [NSRC-1:0] int_start,
    input  logic [NSRC-1:0] intmask,
    input  logic            vdos,
    input  logic            intack,
    input  logic [NSRC-1:0] ovr_clr,
    output logic [7:0]      im2vect,
    output logic            int_n,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] ovr
);
    localparam int               SEL_W    = $clog2(NSRC + 1);
    localparam int               CNT_W    = $clog2(TMO + 1);
    localparam logic [SEL_W-1:0] SEL_DUM  = SEL_W'(NSRC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

    logic [NSRC-1:0]  pending_q, pending_d;
    logic [NSRC-1:0]  ovr_q, ovr_d;
    logic [CNT_W-1:0] tmo_cnt_q [NSRC];
    logic [CNT_W-1:0] tmo_cnt_d [NSRC];
    logic             intack_r_q, intack_r_d;
    logic [SEL_W-1:0] sel_q, sel_d;

    logic             ack_s;
    logic [NSRC-1:0]  lose;
    logic [NSRC-1:0]  blocked;
    logic [NSRC-1:0]  start_ok;
    logic [NSRC-1:0]  vis;
    logic [NSRC-1:0]  win;
    logic [NSRC-1:0]  tmo_hit;
    logic [SEL_W-1:0] win_idx;
    logic [7:0]       sel_ext;

    assign lose = LOSE_MASK[NSRC-1:0];

    always_comb begin
        ack_s      = intack & ~intack_r_q;
        intack_r_d = intack;
        blocked    = ~intmask | ({NSRC{vdos}} & lose);
        start_ok   = int_start & ~blocked;
        // Held sources stay pending in VDOS but are hidden from the CPU.
        vis        = pending_q & ~({NSRC{vdos}} & ~lose);

        // Scan high to low so the lowest visible index wins.
        win_idx = SEL_DUM;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (vis[i]) win_idx = SEL_W'(i);
        end

        win       = '0;
        tmo_hit   = '0;
        pending_d = pending_q;
        ovr_d     = ovr_q;
        for (int i = 0; i < NSRC; i++) begin
            win[i]     = (win_idx == SEL_W'(i));
            tmo_hit[i] = TMO_MASK[i] & (tmo_cnt_q[i] == CNT_LAST);

            // Block beats start; start beats ack and timeout.
            if (blocked[i])              pending_d[i] = 1'b0;
            else if (int_start[i])       pending_d[i] = 1'b1;
            else if (ack_s && win[i])    pending_d[i] = 1'b0;
            else if (tmo_hit[i])         pending_d[i] = 1'b0;

            // Count only while pending; a fresh start restarts the window.
            if (!TMO_MASK[i] || start_ok[i] || !pending_d[i])
                tmo_cnt_d[i] = '0;
            else
                tmo_cnt_d[i] = tmo_cnt_q[i] + CNT_W'(1);

            // Set wins over clear in the same cycle.
            ovr_d[i] = (start_ok[i] & pending_q[i]) | (ovr_q[i] & ~ovr_clr[i]);
        end

        sel_d = ack_s ? win_idx : sel_q;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pending_q  <= '0;
            ovr_q      <= '0;
            intack_r_q <= 1'b0;
            sel_q      <= SEL_DUM;
            for (int i = 0; i < NSRC; i++) tmo_cnt_q[i] <= '0;
        end else begin
            pending_q  <= pending_d;
            ovr_q      <= ovr_d;
            intack_r_q <= intack_r_d;
            sel_q      <= sel_d;
            for (int i = 0; i < NSRC; i++) tmo_cnt_q[i] <= tmo_cnt_d[i];
        end
    end

    // Vector is decoded from the registered selection, so it is stable between acks.
    assign sel_ext = 8'(sel_q);
    assign im2vect = (sel_q == SEL_DUM) ? VECT_DUM : (VECT_BASE - (sel_ext << 1));
    assign int_n   = ~|vis;
    assign pending = pending_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_zint_arb.sv
module tb_zint_arb;
    localparam int         NSRC  = 4;
    localparam logic [7:0] VBASE = 8'hFF;
    localparam logic [7:0] VDUM  = 8'hFF;
    localparam logic [7:0] LOSE  = 8'b0000_0011;
    localparam logic [7:0] TMOM  = 8'b0000_0001;
    localparam int         TMO   = 32;

    logic            clk;
    logic            res_n;
    logic [NSRC-1:0] int_start;
    logic [NSRC-1:0] intmask;
    logic            vdos;
    logic            intack;
    logic [NSRC-1:0] ovr_clr;
    logic [7:0]      im2vect;
    logic            int_n;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] ovr;

    int n_chk  = 0;
    int n_fail = 0;

    zint_arb #(
        .NSRC(NSRC), .VECT_BASE(VBASE), .VECT_DUM(VDUM),
        .LOSE_MASK(LOSE), .TMO_MASK(TMOM), .TMO(TMO)
    ) dut (
        .clk(clk), .res_n(res_n), .int_start(int_start), .intmask(intmask),
        .vdos(vdos), .intack(intack), .ovr_clr(ovr_clr), .im2vect(im2vect),
        .int_n(int_n), .pending(pending), .ovr(ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending set, absolute timeout deadlines, last ack vector.
    logic [NSRC-1:0] m_pend, m_ovr, m_np, m_vis;
    logic [7:0]      m_vec;
    logic            m_prev_ack, m_ack;
    int              m_dl [NSRC];
    int              cyc;
    int              m_win;
    logic            m_blk;

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            m_pend     = '0;
            m_ovr      = '0;
            m_vec      = VDUM;
            m_prev_ack = 1'b0;
            cyc        = 0;
        end else begin
            cyc++;
            m_vis = m_pend & ~({NSRC{vdos}} & ~LOSE[NSRC-1:0]);
            m_win = -1;
            for (int i = 0; i < NSRC; i++) if (m_vis[i] && m_win < 0) m_win = i;
            m_ack = intack && !m_prev_ack;
            m_np  = m_pend;
            for (int i = 0; i < NSRC; i++) begin
                m_blk = !intmask[i] || (vdos && LOSE[i]);
                if (m_blk) begin
                    m_np[i] = 1'b0;
                    if (ovr_clr[i]) m_ovr[i] = 1'b0;
                end else if (int_start[i]) begin
                    if (m_pend[i]) m_ovr[i] = 1'b1;
                    else if (ovr_clr[i]) m_ovr[i] = 1'b0;
                    m_np[i] = 1'b1;
                    m_dl[i] = cyc + TMO;
                end else begin
                    if (ovr_clr[i]) m_ovr[i] = 1'b0;
                    if (m_ack && m_win == i) m_np[i] = 1'b0;
                    else if (TMOM[i] && m_pend[i] && cyc == m_dl[i]) m_np[i] = 1'b0;
                end
            end
            if (m_ack) m_vec = (m_win < 0) ? VDUM : 8'(int'(VBASE) - 2 * m_win);
            m_prev_ack = intack;
            m_pend     = m_np;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        chk("im2vect", {24'd0, im2vect}, {24'd0, m_vec});
        chk("pending", {28'd0, pending}, {28'd0, m_pend});
        chk("ovr", {28'd0, ovr}, {28'd0, m_ovr});
        chk("int_n", {31'd0, int_n},
            {31'd0, ~|(m_pend & ~({NSRC{vdos}} & ~LOSE[NSRC-1:0]))});
    end

    task automatic pulse(input logic [NSRC-1:0] m);
        @(negedge clk);
        int_start = m;
        @(negedge clk);
        int_start = '0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        intack = 1'b1;
        @(negedge clk);
        intack = 1'b0;
        @(negedge clk);
    endtask

    // Pulse source 0 and count int_n low cycles; optional restart in low cycle restart_at.
    task automatic tmo_run(input int restart_at, output int n);
        @(negedge clk);
        int_start[0] = 1'b1;
        @(negedge clk);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            if (int_n === 1'b0) n++;
            else break;
            int_start[0] = (n == restart_at);
            @(negedge clk);
        end
        int_start = '0;
    endtask

    int nlow;

    initial begin
        res_n = 1'b1; int_start = '0; intmask = '1; vdos = 1'b0;
        intack = 1'b0; ovr_clr = '0;
        #2 res_n = 1'b0;
        #1;
        chk("rst_int_n", {31'd0, int_n}, 32'd1);
        chk("rst_vect", {24'd0, im2vect}, 32'hFF);
        chk("rst_pending", {28'd0, pending}, 32'd0);
        chk("rst_ovr", {28'd0, ovr}, 32'd0);
        @(negedge clk);
        res_n = 1'b1;

        // Priority: sources 2 and 1 together.
        pulse(4'b0110);
        chk("prio_pend", {28'd0, pending}, 32'b0110);
        chk("prio_int_n", {31'd0, int_n}, 32'd0);
        do_ack();
        chk("ack1_vect", {24'd0, im2vect}, 32'hFD);
        chk("ack1_pend", {28'd0, pending}, 32'b0100);
        do_ack();
        chk("ack2_vect", {24'd0, im2vect}, 32'hFB);
        chk("ack2_int_n", {31'd0, int_n}, 32'd1);

        // Timeout and restart.
        tmo_run(0, nlow);
        chk("tmo_len", nlow, 32'd32);
        chk("tmo_ovr", {28'd0, ovr}, 32'd0);
        tmo_run(20, nlow);
        chk("restart_len", nlow, 32'd52);
        chk("restart_ovr0", {31'd0, ovr[0]}, 32'd1);
        ovr_clr = 4'b0001;
        @(negedge clk);
        ovr_clr = '0;
        chk("ovr_clr", {28'd0, ovr}, 32'd0);

        // VDOS: 0 is lost, 2 is held.
        pulse(4'b0101);
        vdos = 1'b1;
        @(negedge clk);
        chk("vdos_pend", {28'd0, pending}, 32'b0100);
        chk("vdos_int_n", {31'd0, int_n}, 32'd1);
        repeat (3) @(negedge clk);
        vdos = 1'b0;
        @(negedge clk);
        chk("vdos_off_int_n", {31'd0, int_n}, 32'd0);
        do_ack();
        chk("vdos_ack_vect", {24'd0, im2vect}, 32'hFB);

        // Held ack: only one source cleared.
        pulse(4'b1010);
        @(negedge clk);
        intack = 1'b1;
        repeat (5) @(negedge clk);
        intack = 1'b0;
        @(negedge clk);
        chk("held_pend", {28'd0, pending}, 32'b1000);
        chk("held_vect", {24'd0, im2vect}, 32'hFD);
        do_ack();
        chk("src3_vect", {24'd0, im2vect}, 32'hF9);
        do_ack();
        chk("dummy_vect", {24'd0, im2vect}, 32'hFF);

        // Start and ack on the same source in the same cycle.
        pulse(4'b0010);
        int_start = 4'b0010;
        intack = 1'b1;
        @(negedge clk);
        int_start = '0;
        intack = 1'b0;
        @(negedge clk);
        chk("start_vs_ack_pend", {31'd0, pending[1]}, 32'd1);
        chk("start_vs_ack_vect", {24'd0, im2vect}, 32'hFD);
        chk("start_vs_ack_ovr", {31'd0, ovr[1]}, 32'd1);
        intmask = 4'b1101;
        @(negedge clk);
        chk("mask_clear", {28'd0, pending}, 32'd0);
        pulse(4'b0010);
        chk("masked_start", {28'd0, pending}, 32'd0);
        chk("mask_keeps_ovr", {31'd0, ovr[1]}, 32'd1);
        intmask = '1;
        ovr_clr = 4'b0010;
        @(negedge clk);
        ovr_clr = '0;

        // Asynchronous reset in the middle of an ack.
        pulse(4'b1000);
        pulse(4'b1000);
        @(negedge clk);
        intack = 1'b1;
        @(negedge clk);
        #2 res_n = 1'b0;
        #1;
        chk("arst_int_n", {31'd0, int_n}, 32'd1);
        chk("arst_vect", {24'd0, im2vect}, 32'hFF);
        chk("arst_pend", {28'd0, pending}, 32'd0);
        chk("arst_ovr", {28'd0, ovr}, 32'd0);
        intack = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_int_n", {31'd0, int_n}, 32'd1);
        chk("post_rst_vect", {24'd0, im2vect}, 32'hFF);
        pulse(4'b0100);
        chk("post_rst_start", {31'd0, int_n}, 32'd0);
        do_ack();
        chk("post_rst_ack", {24'd0, im2vect}, 32'hFB);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
